draw_controller: RTL and testbench

Parametrised successor to the keypress-driven draw controller. Draws up to DRAW_COUNT distinct values in 1..MAX_VALUE without replacement: key press starts counting, key release samples an external free-running counter, then a multi-cycle probe finds the next unused value. Probing is one per cycle instead of a combinational loop. Sits between the key synchroniser/free-running counter and the seven-segment display logic. Adds software restart, busy/done status and a draw index.

---
 rtl/draw_pkg.sv | 30 +++
 rtl/draw_flag_store.sv | 36 +++
 rtl/draw_controller.sv | 159 +++++++++++++++
 tb/tb_draw_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types and parameter legality helper for the draw controller.
package draw_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    SEARCH   = 2'd2,
    DONE     = 2'd3
  } draw_state_e;

  function automatic bit params_ok(
    input int max_v,
    input int draws,
    input int value_w,
    input int cnt_w,
    input int idx_w
  );
    return (max_v >= 2) &&
           (draws >= 1) &&
           (draws <= max_v) &&
           (value_w >= 2) && (value_w <= 30) &&
           ((1 << value_w) > max_v) &&
           (cnt_w >= 1) &&
           (idx_w >= 1) && (idx_w <= 30) &&
           ((1 << idx_w) > draws);
  endfunction

endpackage

// File: rtl/draw_flag_store.sv
// Used-value flags: one bit per drawable value, probe read,
// single-bit set and clear-all.
module draw_flag_store #(
  parameter int MAX_VALUE = 92,
  parameter int AW        = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear_i,
  input  logic          set_i,
  input  logic [AW-1:0] addr_i,
  output logic          used_o
);

  logic [MAX_VALUE-1:0] used_q, used_d;

  always_comb begin
    used_d = used_q;
    if (clear_i) begin
      used_d = '0;
    end else if (set_i) begin
      used_d[addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      used_q <= '0;
    end else begin
      used_q <= used_d;
    end
  end

  assign used_o = used_q[addr_i];

endmodule

// File: rtl/draw_controller.sv
// Key-driven draw-without-replacement controller: a release samples
// the free-running counter, then one flag probe per cycle.
module draw_controller #(
  parameter int MAX_VALUE  = 92,
  parameter int DRAW_COUNT = 7,
  parameter int VALUE_W    = 7,
  parameter int CNT_W      = 32,
  parameter int IDX_W      = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               key_count,
  input  logic               restart,
  input  logic [CNT_W-1:0]   counter_value,
  output logic               counting,
  output logic               busy,
  output logic               display_active,
  output logic [VALUE_W-1:0] count_value,
  output logic [IDX_W-1:0]   draw_index,
  output logic               done
);

  import draw_pkg::*;

  if (!params_ok(MAX_VALUE, DRAW_COUNT, VALUE_W, CNT_W, IDX_W))
  begin : g_bad_params
    $error("draw_controller: illegal parameter set");
  end

  localparam int AW = $clog2(MAX_VALUE);

  draw_state_e        state_q, state_d;
  logic               last_key_q;
  logic [VALUE_W-1:0] probe_q, probe_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               counting_q, counting_d;
  logic               busy_q, busy_d;
  logic               disp_q, disp_d;
  logic               done_q, done_d;

  logic               rise, fall;
  logic               used, set_flag, clr_flags;
  logic [CNT_W-1:0]   mod_w;
  logic [VALUE_W-1:0] probe_m1;
  logic [IDX_W-1:0]   idx_next;

  assign rise     = key_count & ~last_key_q;
  assign fall     = ~key_count & last_key_q;
  assign mod_w    = counter_value % CNT_W'(MAX_VALUE);
  assign probe_m1 = probe_q - VALUE_W'(1);
  assign idx_next = idx_q + IDX_W'(1);

  draw_flag_store #(
    .MAX_VALUE (MAX_VALUE),
    .AW        (AW)
  ) u_flags (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (clr_flags),
    .set_i   (set_flag),
    .addr_i  (probe_m1[AW-1:0]),
    .used_o  (used)
  );

  always_comb begin
    state_d    = state_q;
    probe_d    = probe_q;
    value_d    = value_q;
    idx_d      = idx_q;
    counting_d = counting_q;
    busy_d     = busy_q;
    disp_d     = 1'b0;
    done_d     = done_q;
    set_flag   = 1'b0;
    clr_flags  = 1'b0;
    // restart outranks a probe that would succeed this cycle
    if (restart) begin
      state_d    = IDLE;
      idx_d      = '0;
      done_d     = 1'b0;
      counting_d = 1'b0;
      busy_d     = 1'b0;
      clr_flags  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d    = COUNTING;
            counting_d = 1'b1;
          end
        end
        COUNTING: begin
          if (fall) begin
            state_d    = SEARCH;
            probe_d    = VALUE_W'(mod_w) + VALUE_W'(1);
            counting_d = 1'b0;
            busy_d     = 1'b1;
          end
        end
        SEARCH: begin
          if (!used) begin
            set_flag = 1'b1;
            value_d  = probe_q;
            idx_d    = idx_next;
            disp_d   = 1'b1;
            busy_d   = 1'b0;
            if (idx_next == IDX_W'(DRAW_COUNT)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else if (probe_q == VALUE_W'(MAX_VALUE)) begin
            probe_d = VALUE_W'(1);
          end else begin
            probe_d = probe_q + VALUE_W'(1);
          end
        end
        DONE: begin
          done_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_key_q <= 1'b0;
      probe_q    <= '0;
      value_q    <= '0;
      idx_q      <= '0;
      counting_q <= 1'b0;
      busy_q     <= 1'b0;
      disp_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_key_q <= key_count;
      probe_q    <= probe_d;
      value_q    <= value_d;
      idx_q      <= idx_d;
      counting_q <= counting_d;
      busy_q     <= busy_d;
      disp_q     <= disp_d;
      done_q     <= done_d;
    end
  end

  assign counting       = counting_q;
  assign busy           = busy_q;
  assign display_active = disp_q;
  assign count_value    = value_q;
  assign draw_index     = idx_q;
  assign done           = done_q;

endmodule

// File: tb/tb_draw_controller.sv
// Self-checking bench for draw_controller: table of draws plus
// hand-written restart and key-edge corner sequences.
module tb_draw_controller;

  localparam int MAXV  = 92;
  localparam int DRAWS = 7;
  localparam int VW    = 7;
  localparam int CW    = 32;
  localparam int IW    = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          key_count;
  logic          restart;
  logic [CW-1:0] counter_value;
  logic          counting;
  logic          busy;
  logic          display_active;
  logic [VW-1:0] count_value;
  logic [IW-1:0] draw_index;
  logic          done;

  draw_controller #(
    .MAX_VALUE  (MAXV),
    .DRAW_COUNT (DRAWS),
    .VALUE_W    (VW),
    .CNT_W      (CW),
    .IDX_W      (IW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .key_count      (key_count),
    .restart        (restart),
    .counter_value  (counter_value),
    .counting       (counting),
    .busy           (busy),
    .display_active (display_active),
    .count_value    (count_value),
    .draw_index     (draw_index),
    .done           (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] val;
    logic [IW-1:0] idx;
    int            lat;
  } exp_t;

  typedef struct {
    logic [CW-1:0] cv;
    bit            rs;
    bit            poke;
    logic [VW-1:0] val;
    logic [IW-1:0] idx;
    int            lat;
    bit            dn;
  } vec_t;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rel_cyc  = 0;
  int   disp_seen = 0;
  int   d0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[10];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // every display pulse must match the oldest outstanding draw
  always @(negedge clk) begin
    if (display_active === 1'b1) begin
      disp_seen++;
      if (sb.size() == 0) begin
        check("unexpected_display", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("count_value", 32'(count_value), 32'(mon_e.val));
        check("draw_index", 32'(draw_index), 32'(mon_e.idx));
        check("latency", 32'(cyc - rel_cyc - 1), 32'(mon_e.lat));
      end
    end
  end

  task automatic draw(input logic [CW-1:0] cv, input bit poke,
                      input logic [VW-1:0] ev,
                      input logic [IW-1:0] ei, input int el);
    exp_t e;
    @(negedge clk);
    key_count = 1'b1;
    @(negedge clk);
    check("counting_on", 32'(counting), 32'd1);
    key_count     = 1'b0;
    counter_value = cv;
    rel_cyc       = cyc;
    e.val = ev;
    e.idx = ei;
    e.lat = el;
    sb.push_back(e);
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      @(negedge clk);
      #1;
      if (poke && k == 0) key_count = 1'b1;
      if (poke && k == 1) key_count = 1'b0;
      if (sb.size() != 0) check("busy_search", 32'(busy), 32'd1);
    end
    if (sb.size() != 0) begin
      check("draw_timeout", 32'd0, 32'd1);
      sb.delete();
    end else begin
      check("busy_clear", 32'(busy), 32'd0);
    end
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rst_index", 32'(draw_index), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_counting", 32'(counting), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'd0,          0, 0, 7'd1,  3'd1, 1, 0};
    tbl[1] = '{32'd91,         1, 0, 7'd92, 3'd1, 1, 0};
    tbl[2] = '{32'd91,         0, 0, 7'd1,  3'd2, 2, 0};
    tbl[3] = '{32'd5,          1, 0, 7'd6,  3'd1, 1, 0};
    tbl[4] = '{32'd5,          0, 0, 7'd7,  3'd2, 2, 0};
    tbl[5] = '{32'd5,          0, 1, 7'd8,  3'd3, 3, 0};
    tbl[6] = '{32'd97,         0, 0, 7'd9,  3'd4, 4, 0};
    tbl[7] = '{32'd183,        0, 0, 7'd92, 3'd5, 1, 0};
    tbl[8] = '{32'd183,        0, 0, 7'd1,  3'd6, 2, 0};
    tbl[9] = '{32'hFFFF_FFFF,  0, 0, 7'd12, 3'd7, 1, 1};

    reset_n       = 1'b0;
    key_count     = 1'b0;
    restart       = 1'b0;
    counter_value = '0;
    repeat (3) @(negedge clk);
    check("reset_counting", 32'(counting), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_display", 32'(display_active), 32'd0);
    check("reset_value", 32'(count_value), 32'd0);
    check("reset_index", 32'(draw_index), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rs) do_restart();
      draw(tbl[i].cv, tbl[i].poke, tbl[i].val, tbl[i].idx, tbl[i].lat);
      check("done_flag", 32'(done), 32'(tbl[i].dn));
    end

    // session full: a further press/release does nothing
    d0 = disp_seen;
    @(negedge clk);
    key_count = 1'b1;
    @(negedge clk);
    check("done_counting", 32'(counting), 32'd0);
    key_count     = 1'b0;
    counter_value = '0;
    repeat (10) @(negedge clk);
    check("done_no_display", 32'(disp_seen), 32'(d0));
    check("done_value", 32'(count_value), 32'd12);
    check("done_index", 32'(draw_index), 32'd7);
    check("done_held", 32'(done), 32'd1);

    do_restart();
    check("restart_value_hold", 32'(count_value), 32'd12);

    // restart lands on the cycle the first probe succeeds
    d0 = disp_seen;
    @(negedge clk);
    key_count = 1'b1;
    @(negedge clk);
    key_count     = 1'b0;
    counter_value = '0;
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rf_display", 32'(display_active), 32'd0);
    check("rf_index", 32'(draw_index), 32'd0);
    check("rf_done", 32'(done), 32'd0);
    check("rf_busy", 32'(busy), 32'd0);
    check("rf_value", 32'(count_value), 32'd12);
    repeat (3) @(negedge clk);
    check("rf_no_display", 32'(disp_seen), 32'(d0));
    draw(32'd0, 1'b0, 7'd1, 3'd1, 1);

    // key held through restart needs a fresh press
    @(negedge clk);
    key_count = 1'b1;
    @(negedge clk);
    check("held_counting", 32'(counting), 32'd1);
    do_restart();
    repeat (3) @(negedge clk);
    check("held_no_rise", 32'(counting), 32'd0);
    key_count = 1'b0;
    @(negedge clk);
    draw(32'd0, 1'b0, 7'd1, 3'd1, 1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
